da_line_feeder: RTL and testbench

//  Upstream stage of DA_block: it buffers samples from a video producer and plays
//  out one line of exactly LINENUM samples on dout/we, clocked by dack.
//  - Producer side: valid/ready handshake into a small internal FIFO.
//  - Consumer side: drives DA_block din/we directly; one sample per dack edge

---
 rtl/da_line_feeder.sv | 148 ++++++++++++++
 tb/tb_da_line_feeder.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/da_line_feeder.sv
// da_line_feeder: buffers producer samples in a small FIFO and plays out one
// line of LINENUM samples per start request on dout/we, clocked by dack.
// Underrun slots are filled with BLANK_LEVEL and counted.
// Optional build macro DA_FEEDER_CLIP_EN: clamps popped samples to [16,235].
module da_line_feeder #(
  parameter int         LINENUM     = 910,
  parameter int         DEPTH       = 16,
  parameter int         AW          = 4,
  parameter int         PRIME_LEVEL = 8,
  parameter logic [7:0] BLANK_LEVEL = 8'd16
) (
  input  logic       dack,
  input  logic       reset,
  input  logic       start,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       we,
  output logic [7:0] dout,
  output logic       line_end,
  output logic       busy,
  output logic [9:0] underruns
);

  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] PRIME_C = (AW+1)'(PRIME_LEVEL);
  localparam logic [9:0]  LAST_C  = 10'(LINENUM - 1);

  state_t          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     fill_q, fill_d;
  logic [9:0]      cnt_q, cnt_d;
  logic [9:0]      und_q, und_d;
  logic            we_q, we_d;
  logic            le_q, le_d;
  logic [7:0]      dout_q, dout_d;
  logic [7:0]      mem [DEPTH];
  logic            push, pop;

  // Video-legal range clamp for popped samples; pass-through in the default build.
  function automatic logic [7:0] clip_px(input logic [7:0] x);
`ifdef DA_FEEDER_CLIP_EN
    if (x < 8'd16)       return 8'd16;
    else if (x > 8'd235) return 8'd235;
    else                 return x;
`else
    return x;
`endif
  endfunction

  // FIFO handshake: full blocks the producer even when a pop happens on the same edge.
  always_comb begin
    in_ready = (fill_q != DEPTH_C);
    push     = in_valid && in_ready;
    pop      = (state_q == RUN) && (fill_q != '0);
  end

  // Next-state logic for the FIFO pointers, line FSM and registered outputs.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    und_d    = und_q;
    we_d     = we_q;
    le_d     = le_q;
    dout_d   = dout_q;
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   fill_d = fill_q + (AW+1)'(1);
      2'b01:   fill_d = fill_q - (AW+1)'(1);
      default: fill_d = fill_q;
    endcase
    case (state_q)
      IDLE: begin
        we_d = 1'b0;
        le_d = 1'b0;
        if (start) begin
          state_d = PRIME;
          cnt_d   = '0;
          und_d   = '0;
        end
      end
      PRIME: begin
        we_d = 1'b0;
        le_d = 1'b0;
        if (fill_q >= PRIME_C) state_d = RUN;
      end
      RUN: begin
        we_d = 1'b1;
        if (pop) begin
          dout_d = clip_px(mem[rd_ptr_q]);
        end else begin
          dout_d = BLANK_LEVEL;
          und_d  = (und_q == 10'h3FF) ? und_q : und_q + 10'd1;
        end
        if (cnt_q == LAST_C) begin
          le_d    = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          le_d    = 1'b0;
          cnt_d   = cnt_q + 10'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and output registers; reset aborts any line and empties the FIFO.
  always_ff @(posedge dack) begin
    if (reset) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      cnt_q    <= '0;
      und_q    <= '0;
      we_q     <= 1'b0;
      le_q     <= 1'b0;
      dout_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      cnt_q    <= cnt_d;
      und_q    <= und_d;
      we_q     <= we_d;
      le_q     <= le_d;
      dout_q   <= dout_d;
    end
  end

  // FIFO storage: data only, write on an accepted push.
  always_ff @(posedge dack) begin
    if (push) mem[wr_ptr_q] <= in_data;
  end

  assign we        = we_q;
  assign dout      = dout_q;
  assign line_end  = le_q;
  assign underruns = und_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_da_line_feeder.sv
// Directed bench for da_line_feeder: reset state, full ramp line, mid-line
// underrun, full-FIFO backpressure, mid-line reset and the optional clamp.
module tb_da_line_feeder;

  logic       dack = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       in_ready, we, line_end, busy;
  logic [7:0] dout;
  logic [9:0] underruns;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] cap_d  [8192];
  logic       cap_le [8192];
  int         ncap = 0;
  logic [7:0] exp_line [910];
  logic [7:0] pq [$];
  bit         stop_feed = 1'b0;
  int         base;

  da_line_feeder dut (
    .dack      (dack),
    .reset     (reset),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .we        (we),
    .dout      (dout),
    .line_end  (line_end),
    .busy      (busy),
    .underruns (underruns)
  );

  always #5 dack = ~dack;

  // Capture every written sample away from the active edge.
  always @(negedge dack) begin
    if (we === 1'b1) begin
      cap_d[ncap % 8192]  <= dout;
      cap_le[ncap % 8192] <= line_end;
      ncap                <= ncap + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_px(input logic [7:0] v);
`ifdef DA_FEEDER_CLIP_EN
    if (v < 8'd16)  return 8'd16;
    if (v > 8'd235) return 8'd235;
`endif
    return v;
  endfunction

  // Push the queued samples, one per cycle when the FIFO accepts.
  task automatic feed(input int budget);
    int  b = 0;
    bit  stopped = 0;
    while (pq.size() != 0 && b < budget) begin
      @(negedge dack);
      if (stop_feed) begin
        stopped = 1;
        break;
      end
      in_valid = 1'b1;
      in_data  = pq[0];
      if (in_ready) void'(pq.pop_front());
      b++;
    end
    if (!stopped) @(negedge dack);
    in_valid = 1'b0;
    chk("feed_done", pq.size(), stopped ? pq.size() : 0);
  endtask

  task automatic pulse_start();
    @(negedge dack);
    start = 1'b1;
    @(negedge dack);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy && k < 3000) begin
      @(negedge dack);
      #1;
      k++;
    end
    chk({tag, "_idle"}, busy, 0);
    @(negedge dack);
    #1;
    chk({tag, "_we_low"}, we, 0);
  endtask

  task automatic chk_line(input string tag, input int b0);
    int bd = 0;
    int bl = 0;
    for (int i = 0; i < 910; i++) begin
      if (cap_d[(b0 + i) % 8192] !== exp_line[i]) bd++;
      if (cap_le[(b0 + i) % 8192] !== (i == 909)) bl++;
    end
    chk({tag, "_count"}, ncap - b0, 910);
    chk({tag, "_data_err"}, bd, 0);
    chk({tag, "_le_err"}, bl, 0);
  endtask

  initial begin
    // Test 1: reset and idle
    repeat (3) @(negedge dack);
    reset = 1'b0;
    repeat (5) @(negedge dack);
    #1;
    chk("t1_we", we, 0);
    chk("t1_dout", dout, 0);
    chk("t1_busy", busy, 0);
    chk("t1_in_ready", in_ready, 1);
    chk("t1_underruns", underruns, 0);
    chk("t1_line_end", line_end, 0);

    // Test 2: ramp line with producer streaming
    base = ncap;
    for (int i = 0; i < 910; i++) begin
      pq.push_back(8'(i));
      exp_line[i] = exp_px(8'(i));
    end
    fork
      feed(3000);
      begin
        repeat (9) @(negedge dack);
        pulse_start();
        wait_idle("t2");
      end
    join
    chk_line("t2", base);
    chk("t2_underruns", underruns, 0);
    chk("t2_dout_hold", dout, exp_px(8'd141));

    // Test 3: producer stops after 100 samples
    base = ncap;
    for (int i = 0; i < 910; i++)
      exp_line[i] = (i < 100) ? 8'(20 + i) : 8'd16;
    for (int i = 0; i < 100; i++) pq.push_back(8'(20 + i));
    fork
      feed(3000);
      begin
        pulse_start();
        wait_idle("t3");
      end
    join
    chk_line("t3", base);
    chk("t3_underruns", underruns, 810);

    // Test 4: full FIFO in IDLE, 17th push refused
    for (int i = 0; i < 16; i++) pq.push_back(8'(30 + 5 * i));
    feed(100);
    #1;
    chk("t4_full_ready", in_ready, 0);
    chk("t4_no_start_busy", busy, 0);
    @(negedge dack);
    in_valid = 1'b1;
    in_data  = 8'hAA;
    @(negedge dack);
    in_valid = 1'b0;
    #1;
    chk("t4_still_full", in_ready, 0);
    base = ncap;
    for (int i = 0; i < 910; i++)
      exp_line[i] = (i < 16) ? 8'(30 + 5 * i) : 8'd16;
    pulse_start();
    wait_idle("t4");
    chk_line("t4", base);
    chk("t4_underruns", underruns, 894);

    // Test 5: reset at sample 300
    base = ncap;
    for (int i = 0; i < 400; i++) pq.push_back(8'(64 + i));
    fork
      feed(3000);
      begin
        int k = 0;
        pulse_start();
        while ((ncap - base) < 300 && k < 3000) begin
          @(negedge dack);
          #1;
          k++;
        end
        chk("t5_reach300", ncap - base, 300);
        stop_feed = 1'b1;
        reset     = 1'b1;
        @(negedge dack);
        #1;
        chk("t5_we", we, 0);
        chk("t5_busy", busy, 0);
        chk("t5_in_ready", in_ready, 1);
        chk("t5_underruns", underruns, 0);
        chk("t5_line_end", line_end, 0);
        reset = 1'b0;
      end
    join
    stop_feed = 1'b0;
    pq.delete();
    repeat (3) @(negedge dack);
    #1;
    chk("t5_count", ncap - base, 300);
    for (int i = 0; i < 7; i++) pq.push_back(8'(90 + i));
    feed(100);
    base = ncap;
    pulse_start();
    repeat (20) @(negedge dack);
    #1;
    chk("t5_prime_busy", busy, 1);
    chk("t5_prime_no_we", ncap - base, 0);
    pq.push_back(8'd97);
    for (int i = 0; i < 910; i++)
      exp_line[i] = (i < 8) ? 8'(90 + i) : 8'd16;
    fork
      feed(100);
      wait_idle("t5b");
    join
    chk_line("t5b", base);
    chk("t5b_underruns", underruns, 902);

    // Test 6: clamp behaviour
    base = ncap;
    pq.push_back(8'd0);
    pq.push_back(8'd255);
    pq.push_back(8'd100);
    for (int i = 0; i < 5; i++) pq.push_back(8'd50);
    feed(100);
    pulse_start();
    wait_idle("t6");
    chk("t6_count", ncap - base, 910);
`ifdef DA_FEEDER_CLIP_EN
    chk("t6_s0", cap_d[base % 8192], 16);
    chk("t6_s1", cap_d[(base + 1) % 8192], 235);
`else
    chk("t6_s0", cap_d[base % 8192], 0);
    chk("t6_s1", cap_d[(base + 1) % 8192], 255);
`endif
    chk("t6_s2", cap_d[(base + 2) % 8192], 100);
    chk("t6_s8", cap_d[(base + 8) % 8192], 16);
    chk("t6_underruns", underruns, 902);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
